// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register: req/ack data-memory port, upstream stall, WB capture.
// Optional DM_TIMEOUT_EN aborts a WAIT that exceeds TIMEOUT_CYCLES and raises sticky dm_err.
module mem_wb_stage #(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   MEM_pc,
  input  logic [31:0]   MEM_pc4,
  input  logic [31:0]   MEM_inst,
  input  logic [1:0]    MEM_wdsel,
  input  logic          MEM_rfwe,
  input  logic          MEM_dmwe,
  input  logic [31:0]   MEM_ext,
  input  logic [31:0]   MEM_rfrD2,
  input  logic [31:0]   MEM_aluc,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata,
  input  logic          dm_ack,
  output logic          mem_stall,
  output logic [31:0]   WB_pc,
  output logic [31:0]   WB_inst,
  output logic          WB_rfwe,
  output logic [4:0]    WB_wR,
  output logic [31:0]   WB_wD,
  output logic          dm_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        need_mem, abort, req_act, bubble;
  logic [31:0] wd_sel;
  logic [31:0] wb_pc_q, wb_pc_d, wb_inst_q, wb_inst_d, wb_wd_q, wb_wd_d;
  logic        wb_rfwe_q, wb_rfwe_d;
  logic [4:0]  wb_wr_q, wb_wr_d;

`ifdef DM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    need_mem = MEM_dmwe | (MEM_wdsel == 2'd1);
    state_d  = state_q;
    abort    = 1'b0;
`ifdef DM_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    if (state_q == IDLE) begin
      if (need_mem && !dm_ack) begin
        state_d = WAIT;
`ifdef DM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
    end else begin
      if (dm_ack) begin
        state_d = IDLE;
`ifdef DM_TIMEOUT_EN
      end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
        abort   = 1'b1;
        state_d = IDLE;
        err_d   = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d   = cnt_q + 1'b1;
`endif
      end
    end

    // Gated by rst_n so the port drops the moment reset asserts, even if inputs still ask for memory.
    req_act   = rst_n & ~abort & (need_mem | (state_q == WAIT));
    dm_req    = req_act;
    dm_we     = req_act & MEM_dmwe;
    dm_addr   = req_act ? MEM_aluc[AW-1:0] : '0;
    dm_wdata  = req_act ? MEM_rfrD2 : 32'd0;
    mem_stall = req_act & ~dm_ack;

    case (MEM_wdsel)
      2'd0:    wd_sel = MEM_aluc;
      2'd1:    wd_sel = dm_rdata;
      2'd2:    wd_sel = MEM_pc4;
      default: wd_sel = MEM_ext;
    endcase

    // An aborted access lets upstream advance but its instruction never reaches writeback.
    bubble    = mem_stall | abort;
    wb_pc_d   = bubble ? 32'd0 : MEM_pc;
    wb_inst_d = bubble ? 32'd0 : MEM_inst;
    wb_rfwe_d = bubble ? 1'b0  : MEM_rfwe;
    wb_wr_d   = bubble ? 5'd0  : MEM_inst[11:7];
    wb_wd_d   = bubble ? 32'd0 : wd_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wb_pc_q   <= 32'd0;
      wb_inst_q <= 32'd0;
      wb_rfwe_q <= 1'b0;
      wb_wr_q   <= 5'd0;
      wb_wd_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      wb_pc_q   <= wb_pc_d;
      wb_inst_q <= wb_inst_d;
      wb_rfwe_q <= wb_rfwe_d;
      wb_wr_q   <= wb_wr_d;
      wb_wd_q   <= wb_wd_d;
    end
  end

`ifdef DM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign dm_err = err_q;
`else
  assign dm_err = 1'b0;
`endif

  assign WB_pc   = wb_pc_q;
  assign WB_inst = wb_inst_q;
  assign WB_rfwe = wb_rfwe_q;
  assign WB_wR   = wb_wr_q;
  assign WB_wD   = wb_wd_q;

endmodule
